// File: rtl/keccak_pkg.sv
// Shared definitions for the sequential Keccak theta engine.
// Contents:
//   NLANE_X  - number of lanes along x (columns per slice)
//   state_t  - FSM state encoding (IDLE, PAR, APPLY, DONE)
//   idx()    - lane index 5*y+x inside a 25-bit slice
//   pos()    - vector bit position of lane (x,y); lane index 0 is the MSB
//   col_xor  - column parity of one x column in a slice
package keccak_pkg;

  localparam int NLANE_X = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAR   = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int idx(input int x, input int y);
    return 5 * y + x;
  endfunction

  // Slices are numbered [0:24] with index 0 at the MSB of a [24:0] vector.
  function automatic int pos(input int x, input int y);
    return 24 - idx(x, y);
  endfunction

  function automatic logic col_xor(input logic [24:0] s, input int x);
    logic p;
    p = 1'b0;
    for (int y = 0; y < 5; y++) begin
      p = p ^ s[pos(x, y)];
    end
    return p;
  endfunction

endpackage

// File: rtl/keccak_theta_seq_if.sv
// Bus between the round controller / state memory and the theta engine.
// Signals:
//   start, done, busy          - run request and status
//   in                         - slice read data (combinational on mem_adr)
//   mem_adr, mem_in            - slice address and write data
//   mem_r, mem_w               - read / write strobes
// Modports: slave = theta engine, master = controller plus memory side.
interface keccak_theta_seq_if #(
  parameter int ADR_W = 6
);
  logic              start;
  logic              done;
  logic              busy;
  logic [24:0]       in;
  logic [ADR_W-1:0]  mem_adr;
  logic [24:0]       mem_in;
  logic              mem_r;
  logic              mem_w;

  modport slave (
    input  start, in,
    output done, busy, mem_adr, mem_in, mem_r, mem_w
  );

  modport master (
    output start, in,
    input  done, busy, mem_adr, mem_in, mem_r, mem_w
  );
endinterface

// File: rtl/keccak_theta_slice.sv
// Combinational per-slice theta datapath.
// Ports:
//   slice_in  - 25-bit slice A[.][.][z]
//   col_par   - column parity C[x][z] of slice_in, bit x = column x
//   c_z       - stored C[.][z]
//   c_zm1     - stored C[.][z-1 mod W]
//   slice_out - slice_in with D[x][z] XORed into every lane of column x
module keccak_theta_slice
  import keccak_pkg::*;
(
  input  logic [24:0] slice_in,
  output logic [4:0]  col_par,
  input  logic [4:0]  c_z,
  input  logic [4:0]  c_zm1,
  output logic [24:0] slice_out
);

  // Column parity and theta correction: D[x] = C[x-1][z] ^ C[x+1][z-1].
  always_comb begin
    col_par   = 5'd0;
    slice_out = slice_in;
    for (int x = 0; x < NLANE_X; x++) begin
      col_par[x] = col_xor(slice_in, x);
      for (int y = 0; y < 5; y++) begin
        slice_out[pos(x, y)] = slice_in[pos(x, y)]
                             ^ c_z[(x + 4) % 5]
                             ^ c_zm1[(x + 1) % 5];
      end
    end
  end

endmodule

// File: rtl/keccak_theta_seq.sv
// Sequential Keccak-f theta step over a slice-organised state memory.
// Pass PAR reads slices 0..W-1 and stores the column parities C[x][z];
// pass APPLY re-reads each slice and writes A ^ D back in place.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - keccak_theta_seq_if slave (start/done/busy and memory port)
module keccak_theta_seq
  import keccak_pkg::*;
#(
  parameter int W     = 64,
  parameter int ADR_W = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  keccak_theta_seq_if.slave    bus
);

  localparam logic [ADR_W-1:0] ZERO  = {ADR_W{1'b0}};
  localparam logic [ADR_W-1:0] ONE   = ADR_W'(1);
  localparam logic [ADR_W-1:0] ZLAST = ADR_W'(W - 1);

  state_t            state_r;
  logic [ADR_W-1:0]  z_r;
  logic [5*W-1:0]    par_r;
  logic              done_r;
  logic              busy_r;
  logic              mem_r_r;
  logic              mem_w_r;

  logic [ADR_W-1:0]  zm1_s;
  logic [4:0]        col_par_s;
  logic [4:0]        c_z_s;
  logic [4:0]        c_zm1_s;
  logic [24:0]       theta_s;
  logic [24:0]       mem_in_s;

  // Previous slice index with wrap; for W=1 this is slice 0 again.
  always_comb begin
    if (z_r == ZERO) begin
      zm1_s = ZLAST;
    end else begin
      zm1_s = z_r - ONE;
    end
    c_z_s   = par_r[int'(z_r) * 5 +: 5];
    c_zm1_s = par_r[int'(zm1_s) * 5 +: 5];
  end

  keccak_theta_slice u_slice (
    .slice_in  (bus.in),
    .col_par   (col_par_s),
    .c_z       (c_z_s),
    .c_zm1     (c_zm1_s),
    .slice_out (theta_s)
  );

  // Write data is only meaningful during APPLY; held at zero otherwise.
  always_comb begin
    if (state_r == APPLY) begin
      mem_in_s = theta_s;
    end else begin
      mem_in_s = 25'd0;
    end
  end

  // FSM, slice counter, parity buffer and registered strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      z_r     <= ZERO;
      par_r   <= {(5*W){1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      mem_r_r <= 1'b0;
      mem_w_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r <= PAR;
            z_r     <= ZERO;
            busy_r  <= 1'b1;
            mem_r_r <= 1'b1;
          end
        end
        PAR: begin
          par_r[int'(z_r) * 5 +: 5] <= col_par_s;
          if (z_r == ZLAST) begin
            state_r <= APPLY;
            z_r     <= ZERO;
            mem_w_r <= 1'b1;
          end else begin
            z_r <= z_r + ONE;
          end
        end
        APPLY: begin
          if (z_r == ZLAST) begin
            state_r <= DONE;
            z_r     <= ZERO;
            mem_r_r <= 1'b0;
            mem_w_r <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            z_r <= z_r + ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          z_r     <= ZERO;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          mem_r_r <= 1'b0;
          mem_w_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
  assign bus.mem_r   = mem_r_r;
  assign bus.mem_w   = mem_w_r;
  assign bus.mem_adr = z_r;
  assign bus.mem_in  = mem_in_s;

endmodule

// File: tb/tb_keccak_theta_seq.sv
// Scoreboard bench for keccak_theta_seq: one W=64 instance and one W=1
// instance, each with its own slice memory model. Stimulus pushes the
// expected done cycle and final memory image; a negedge monitor pops and
// compares on every done pulse.
module tb_keccak_theta_seq;

  typedef struct {
    int          cyc;
    logic [24:0] img [64];
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [24:0] mem [2][64];
  exp_t        sbq0[$];
  exp_t        sbq1[$];
  exp_t        ex;
  logic [24:0] pa, pb;

  keccak_theta_seq_if #(.ADR_W(6)) bus64 ();
  keccak_theta_seq_if #(.ADR_W(6)) bus1 ();

  keccak_theta_seq #(.W(64), .ADR_W(6)) dut64 (
    .clock (clock),
    .reset (reset),
    .bus   (bus64.slave)
  );

  keccak_theta_seq #(.W(1), .ADR_W(6)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  assign bus64.in = mem[0][bus64.mem_adr];
  assign bus1.in  = mem[1][bus1.mem_adr];

  always @(posedge clock) begin
    if (bus64.mem_w) mem[0][bus64.mem_adr] <= bus64.mem_in;
    if (bus1.mem_w)  mem[1][bus1.mem_adr]  <= bus1.mem_in;
  end

  function automatic logic [24:0] bm(input int i);
    logic [24:0] one;
    one = 25'd1;
    return one << (24 - i);
  endfunction

  task automatic check(input string name, input logic ok, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic clear_mem();
    for (int d = 0; d < 2; d++)
      for (int z = 0; z < 64; z++) mem[d][z] = 25'd0;
  endtask

  task automatic clear_ex();
    for (int z = 0; z < 64; z++) ex.img[z] = 25'd0;
  endtask

  task automatic compare_img(input string name, input int d);
    int bad, first;
    bad = 0;
    first = -1;
    for (int z = 0; z < 64; z++) begin
      if (mem[d][z] !== ex.img[z]) begin
        bad++;
        if (first < 0) first = z;
      end
    end
    if (first < 0) first = 0;
    check(name, bad == 0,
          $sformatf("%0d bad slices, slice %0d got %h want %h",
                    bad, first, mem[d][first], ex.img[first]));
  endtask

  task automatic on_done(input int d);
    exp_t e;
    int   bad, first;
    if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
      check($sformatf("extra_done_%0d", d), 1'b0,
            $sformatf("done at cycle %0d got 1 want no pulse", cyc));
      return;
    end
    if (d == 0) e = sbq0.pop_front();
    else        e = sbq1.pop_front();
    check($sformatf("done_cycle_%0d", d), cyc == e.cyc,
          $sformatf("got %0d want %0d", cyc, e.cyc));
    bad = 0;
    first = 0;
    for (int z = 0; z < 64; z++) begin
      if (mem[d][z] !== e.img[z]) begin
        if (bad == 0) first = z;
        bad++;
      end
    end
    check($sformatf("result_mem_%0d", d), bad == 0,
          $sformatf("%0d bad slices, slice %0d got %h want %h",
                    bad, first, mem[d][first], e.img[first]));
  endtask

  // Monitor: compares against the scoreboard whenever done is presented.
  always @(negedge clock) begin
    if (reset && bus64.done === 1'b1) on_done(0);
    if (reset && bus1.done === 1'b1)  on_done(1);
  end

  // Issues a one-cycle start; returns at the negedge after the sampling edge.
  task automatic kick(input int d, input int w, output int s);
    @(negedge clock);
    s = cyc + 1;
    ex.cyc = s + 2 * w;
    if (d == 0) begin sbq0.push_back(ex); bus64.start = 1'b1; end
    else        begin sbq1.push_back(ex); bus1.start  = 1'b1; end
    @(negedge clock);
    bus64.start = 1'b0;
    bus1.start  = 1'b0;
  endtask

  task automatic drain(input string name, input int d);
    int left;
    for (int k = 0; k < 400; k++) begin
      left = (d == 0) ? sbq0.size() : sbq1.size();
      if (left == 0) break;
      @(negedge clock);
    end
    left = (d == 0) ? sbq0.size() : sbq1.size();
    check(name, left == 0, $sformatf("pending done got %0d want 0", left));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s, busy_err, done_err;
    bus64.start = 1'b0;
    bus1.start  = 1'b0;
    clear_mem();
    pa = bm(0) | bm(1) | bm(6) | bm(11) | bm(16) | bm(21);
    pb = bm(4) | bm(9) | bm(14) | bm(19) | bm(24);

    // Reset state
    repeat (2) @(negedge clock);
    check("reset_outputs",
          {bus64.done, bus64.busy, bus64.mem_r, bus64.mem_w} == 4'b0000 &&
          bus64.mem_adr == 6'd0 && bus64.mem_in == 25'd0,
          $sformatf("d/b/r/w=%b%b%b%b adr=%0d din=%h want 0", bus64.done,
                    bus64.busy, bus64.mem_r, bus64.mem_w, bus64.mem_adr, bus64.mem_in));
    reset = 1'b1;
    @(negedge clock);

    // Test 1: all-zero memory, busy/done timing
    clear_ex();
    kick(0, 64, s);
    busy_err = 0;
    done_err = 0;
    for (int k = 0; k <= 129; k++) begin
      if (bus64.busy !== (k <= 128)) busy_err++;
      if (bus64.done !== (k == 128)) done_err++;
      @(negedge clock);
    end
    check("zero_busy_window", busy_err == 0, $sformatf("got %0d bad cycles want 0", busy_err));
    check("zero_done_window", done_err == 0, $sformatf("got %0d bad cycles want 0", done_err));
    drain("zero_drain", 0);

    // Test 2: lane (0,0) set in slice 0
    clear_mem(); clear_ex();
    mem[0][0] = bm(0);
    ex.img[0] = pa; ex.img[1] = pb;
    kick(0, 64, s);
    drain("slice0_drain", 0);

    // Test 3: lane (0,0) set in slice 63, D wraps into slice 0
    clear_mem(); clear_ex();
    mem[0][63] = bm(0);
    ex.img[63] = pa; ex.img[0] = pb;
    kick(0, 64, s);
    drain("wrap_drain", 0);

    // Test 4: W=1, both D terms come from slice 0
    clear_mem(); clear_ex();
    mem[1][0] = bm(0);
    ex.img[0] = pa | pb;
    kick(1, 1, s);
    drain("w1_drain", 1);

    // Test 5: start re-asserted in PAR and APPLY is ignored
    clear_mem(); clear_ex();
    mem[0][0] = bm(0);
    ex.img[0] = pa; ex.img[1] = pb;
    kick(0, 64, s);
    repeat (9) @(negedge clock);
    bus64.start = 1'b1;
    @(negedge clock);
    bus64.start = 1'b0;
    repeat (70) @(negedge clock);
    bus64.start = 1'b1;
    @(negedge clock);
    bus64.start = 1'b0;
    drain("restart_drain", 0);
    repeat (5) @(negedge clock);
    check("restart_idle", bus64.busy === 1'b0, $sformatf("busy got %b want 0", bus64.busy));

    // Test 6: reset in APPLY at z=10, no rollback, then a clean run
    clear_mem();
    mem[0][5]  = bm(0);
    mem[0][20] = bm(0);
    @(negedge clock);
    s = cyc + 1;
    bus64.start = 1'b1;
    @(negedge clock);
    bus64.start = 1'b0;
    repeat (74) @(negedge clock);
    check("apply_z10", bus64.mem_adr == 6'd10 && bus64.mem_w === 1'b1,
          $sformatf("adr got %0d w=%b want 10 w=1", bus64.mem_adr, bus64.mem_w));
    #1 reset = 1'b0;
    #1;
    check("async_reset_drop",
          {bus64.done, bus64.busy, bus64.mem_r, bus64.mem_w} == 4'b0000,
          $sformatf("d/b/r/w got %b%b%b%b want 0000",
                    bus64.done, bus64.busy, bus64.mem_r, bus64.mem_w));
    clear_ex();
    ex.img[5] = pa; ex.img[6] = pb; ex.img[20] = bm(0);
    compare_img("partial_mem", 0);
    @(negedge clock);
    reset = 1'b1;
    clear_mem(); clear_ex();
    mem[0][0] = bm(0);
    ex.img[0] = pa; ex.img[1] = pb;
    kick(0, 64, s);
    drain("after_reset_drain", 0);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keccak_theta_seq.md
Name: keccak_theta_seq

Overview:
- Sequential Keccak-f theta step over a slice-organised state memory, parametrised in lane width W (1..64), replacing the fixed single-mode column-parity engine.
- Pass 1 reads every slice and builds the column-parity array C[x][z].
- Pass 2 reads every slice again, XORs in D[x][z] and writes it back in place.
- Sits between the round controller and the shared state Memory's 25-bit slice port.

Parameters:
- W, 64, lane width in bits = number of slices; power of two, 1..64.
- ADR_W, 6, slice address width; must satisfy 2**ADR_W >= W (memory port is 6 bits).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled request; honoured only in IDLE.
- done  output  1  one-cycle pulse when the full theta pass has been written.
- busy  output  1  high in every state except IDLE.
- in  input  25  slice data from memory (mem out25); combinational read of mem_adr.
- mem_adr  output  ADR_W  slice index z.
- mem_in  output  25  write data to memory.
- mem_r  output  1  read strobe.
- mem_w  output  1  write strobe; memory writes on the rising edge.

Behaviour:
- Slice bit mapping: bit index i = 5*y + x in [0:24] order (index 0 is MSB), lane (x,y).
- Theta equations:
  - C[x][z] = XOR over y of A[x][y][z].
  - D[x][z] = C[(x+4)%5][z] ^ C[(x+1)%5][(z-1) mod W].
  - A'[x][y][z] = A[x][y][z] ^ D[x][z].
- Reset (reset=0, asynchronous): state=IDLE, z counter=0, parity buffer (5*W bits) cleared, done=0, busy=0, mem_r=0, mem_w=0, mem_adr=0, mem_in=0.
- FSM IDLE: all strobes low. start=1 at an edge -> PAR, z=0.
- FSM PAR: mem_r=1, mem_adr=z. At each edge, capture C[.][z] from in into the buffer and increment z. Edge with z=W-1 -> APPLY, z=0.
- FSM APPLY: mem_r=1, mem_w=1, mem_adr=z, mem_in = in ^ D-expanded. The memory writes at the edge and z increments. Edge with z=W-1 -> DONE.
- FSM DONE: done=1, strobes low; next edge -> IDLE.
- Latency: taking the start-sampling edge as cycle 0, PAR occupies cycles 1..W, APPLY occupies W+1..2W, and done is high in cycle 2W+1.
- If start is still high in IDLE after DONE, a new run begins at the next edge; there is no dead cycle requirement.
- start while busy=1 is ignored; no queueing.
- Wrap-around: z-1 at z=0 uses slice W-1. For W=1 both terms use slice 0.
- Outputs mem_* and done are registered-state-decoded (Moore), except mem_in, which is combinational from in and the buffer.
- Reset mid-operation: strobes drop immediately (asynchronous). Slices already written stay modified and remaining slices are untouched; no rollback.
- Upper address bits above log2(W) are always 0.

Decomposition:
- keccak_pkg holds:
  - the lane index function idx(x,y)=5*y+x;
  - constant NLANE_X=5;
  - the FSM state encoding (IDLE, PAR, APPLY, DONE).
- One combinational sub-module, keccak_theta_slice, provides:
  - a 25-bit slice in -> 5-bit column parity out;
  - a 25-bit slice plus C[z] and C[z-1] in -> 25-bit theta-applied slice out.
- The top level holds the FSM, z counter and parity buffer.

Test Plan:
- W=64, all-zero memory, start pulse at cycle 0 -> memory stays all-zero; busy high cycles 1..129; done high only at cycle 129.
- W=64, slice 0 bit 0 set (lane 0,0), rest zero -> slice 0 = bits {0,1,6,11,16,21}, slice 1 = bits {4,9,14,19,24}, all other slices zero.
- W=64, slice 63 bit 0 set -> slice 63 = bits {0,1,6,11,16,21}, slice 0 = bits {4,9,14,19,24} (z wrap), others zero.
- W=1, slice 0 bit 0 set -> slice 0 = bits {0,1,6,11,16,21,4,9,14,19,24}; done at cycle 3.
- W=64, start re-asserted during PAR and APPLY -> no restart; exactly one done pulse, at cycle 129; result identical to the single-start run.
- W=64, reset driven low while in APPLY at z=10 -> mem_r, mem_w, busy and done go 0 without waiting for an edge; slices 0..9 modified, slices 10..63 unchanged; a subsequent start completes normally.
